// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed DIGITS-digit seven-segment driver with
// blanking interval, leading-zero suppression and registered outputs.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   load         : one-cycle capture strobe for bcd_in, dp_in, blank_lz
//   bcd_in       : packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   dp_in        : decimal point per digit
//   blank_lz     : leading-zero suppression enable
//   Segment      : ABCDEFG, A on bit 6 (inverted when ACTIVE_LOW_SEG=1)
//   dp_out       : decimal point of the active digit (inverted when ACTIVE_LOW_SEG=1)
//   digit_en     : one-hot active-high digit enable
//   frame_start  : one-cycle pulse on the first output cycle of slot 0
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int ACTIVE_LOW_SEG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            Segment,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_start
);
    localparam int   PW  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW_SEG != 0);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     dps_q, dps_d;
    logic                  lz_q, lz_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic [DIGITS-1:0]     en_q, en_d;
    logic                  wrap_q, wrap_d;
    logic                  fs_q, fs_d;
    logic                  slot_end, zero_above, sup, dpc;
    logic [3:0]            code;
    logic [6:0]            dec;
    logic [DIGITS-1:0]     onehot;

    always_comb begin
        slot_end = presc_q == PW'(REFRESH_DIV - 1);
        presc_d  = slot_end ? '0 : presc_q + PW'(1);
        idx_d    = !slot_end ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        wrap_d   = slot_end && idx_q == IW'(DIGITS - 1);
        bcd_d    = load ? bcd_in : bcd_q;
        dps_d    = load ? dp_in : dps_q;
        lz_d     = load ? blank_lz : lz_q;
        // Walk from the top digit down so zero_above covers every index >= k.
        zero_above = 1'b1;
        code       = 4'd0;
        sup        = 1'b0;
        dpc        = 1'b0;
        onehot     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && bcd_q[4*k +: 4] == 4'd0 && !dps_q[k];
            onehot[k]  = idx_q == IW'(k);
            if (idx_q == IW'(k)) begin
                code = bcd_q[4*k +: 4];
                dpc  = dps_q[k];
                sup  = lz_q && zero_above && k != 0;
            end
        end
        case (code)
            4'd0:    dec = 7'b1111110;
            4'd1:    dec = 7'b0110000;
            4'd2:    dec = 7'b1101101;
            4'd3:    dec = 7'b1111001;
            4'd4:    dec = 7'b0110011;
            4'd5:    dec = 7'b1011011;
            4'd6:    dec = 7'b1011111;
            4'd7:    dec = 7'b1110000;
            4'd8:    dec = 7'b1111111;
            4'd9:    dec = 7'b1111011;
            default: dec = 7'b0000001;
        endcase
        seg_d = (sup ? 7'b0 : dec) ^ {7{INV}};
        dpo_d = (!sup && dpc) ^ INV;
        // int' cast keeps the comparison non-constant when BLANK_CYC is 0.
        en_d  = (int'(presc_q) >= BLANK_CYC && !sup) ? onehot : '0;
        // wrap_q marks the edge that moved the scan to slot 0; the output
        // register shows that slot one edge later, so frame_start follows it.
        fs_d  = wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            dps_q   <= '0;
            lz_q    <= 1'b0;
            seg_q   <= {7{INV}};
            dpo_q   <= INV;
            en_q    <= '0;
            wrap_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            dps_q   <= dps_d;
            lz_q    <= lz_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
            fs_q    <= fs_d;
        end
    end

    assign Segment     = seg_q;
    assign dp_out      = dpo_q;
    assign digit_en    = en_q;
    assign frame_start = fs_q;
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a DIGITS-digit common-segment seven-segment display. It latches a packed BCD word, scans one digit at a time with a programmable dwell time and an anti-ghosting blank interval, and produces registered ABCDEFG segment, decimal-point and one-hot digit-enable outputs. Optional leading-zero suppression is provided. It is the multi-digit, clocked successor of the single-digit BCD-to-seven-segment decoder and sits between the numeric datapath and the board display pins.

## Interface
- DIGITS, 4: number of digits, legal 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, at least BLANK_CYC+1.
- BLANK_CYC, 2: cycles at the start of each slot with digit_en forced low, legal 0..REFRESH_DIV-1.
- ACTIVE_LOW_SEG, 0: when 1, Segment and dp_out are inverted at the output register. digit_en is never inverted.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle capture strobe for bcd_in, dp_in and blank_lz.
- bcd_in  in  4*DIGITS  packed digits. Digit k is bcd_in[4k+3:4k], and digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit.
- blank_lz  in  1  leading-zero suppression enable.
- Segment  out  7  ABCDEFG, with A on bit 6.
- dp_out  out  1  decimal point for the active digit.
- digit_en  out  DIGITS  one-hot digit enable, active high.
- frame_start  out  1  one-cycle pulse when the scan index wraps to 0.

## Operation
- Shadow registers hold the BCD word, the dp bits and the lz flag. They capture on any clock edge where load=1, and a capture mid-slot takes effect immediately.
- Prescaler counts 0..REFRESH_DIV-1 and then wraps. At the wrap, the scan index advances k→k+1, and DIGITS-1→0.
- Decode, combinational from the shadow digit at the current index:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 all decode to 0000001 (dash).
- Leading-zero suppression, when lz=1:
  - Digit k is suppressed if all of the following hold: its code is 0, every digit above k is 0, no dp bit at index ≥k is set, and k≠0.
  - A suppressed slot drives the blank segment pattern, drives dp off, and keeps digit_en low for the whole slot.
- Blank interval: while the prescaler is below BLANK_CYC, digit_en is 0. Segment and dp_out already carry the current slot's pattern during this interval.
- Blank pattern is 0000000 with dp 0 when ACTIVE_LOW_SEG=0, and 1111111 with dp 1 when ACTIVE_LOW_SEG=1.
- All outputs are registered. In each cycle they reflect the prescaler, index and shadow contents of the previous cycle.

## Timing
- Reset (rst_n=0, asynchronous, effective immediately):
  - Prescaler, index and shadows go to 0.
  - Segment and dp_out take the blank pattern. digit_en=0 and frame_start=0.
  - Reset mid-slot or mid-frame discards all scan progress.
- First edge after release: prescaler=0 and index=0. Outputs show slot 0 in its blank interval.
- Slot timing: digit_en is high for REFRESH_DIV−BLANK_CYC consecutive cycles per slot. Frame period is DIGITS·REFRESH_DIV cycles.
- load latency: load is asserted at edge n, the shadow updates at edge n, and outputs reflect the new value at edge n+1.
- frame_start is high for exactly one cycle, aligned with the first output cycle of slot 0. It is not asserted on the first slot after reset.
- load and a slot boundary on the same edge: the new slot uses the newly loaded data.
- DIGITS=1: index stays 0 and frame_start pulses every REFRESH_DIV cycles.
- BLANK_CYC=0: there is no gap, and digit_en is continuously one-hot after the first output cycle.

## Test plan
Parameters for all scenarios are DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2 unless a scenario states otherwise.
- Reset: hold rst_n=0 for 5 cycles with load=1 and bcd_in=0x8888.
  - Required: Segment=0000000, dp_out=0, digit_en=0000, frame_start=0 throughout.
- Basic scan: load bcd_in=0x1234, dp_in=0, blank_lz=0.
  - Slot 0 shows Segment=0110011 with digit_en=0001 for 6 cycles, after 2 cycles of 0000.
  - Slot 3 shows 0110000 with digit_en=1000.
  - frame_start pulses every 32 cycles.
- Leading-zero suppression: bcd_in=0x0070, blank_lz=1.
  - Slots 3 and 2 show Segment=0000000 with digit_en=0000.
  - Slot 1 shows 1110000 and slot 0 shows 1111110.
  - Repeat with dp_in=0100: slot 2 shows 1111110 with dp_out=1, and slot 3 remains suppressed.
- Invalid code and mid-slot load:
  - bcd_in=0x000A shows 0000001 in slot 0.
  - Pulse load with 0x0005 at prescaler=4 of slot 0. Segment becomes 1011011 2 edges later, and digit_en stays 0001 without a gap.
- Reset mid-frame: assert rst_n=0 during slot 2.
  - Outputs go blank before the next clock edge.
  - After release, the scan restarts at slot 0 with the blank interval.
- Polarity: ACTIVE_LOW_SEG=1 with bcd_in=0x0008, dp_in=0001.
  - Slot 0 shows Segment=0000000 and dp_out=0.
  - During reset, Segment=1111111 and dp_out=1.
